// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge magnitude over raster-order 8-bit pixels, interior outputs only.
// Define SOBEL_THRESH_EN to binarise the output against THRESHOLD instead of saturating.
module sobel_stream_filter #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int THRESHOLD  = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  output logic       busy,
  output logic       frame_done,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);
  localparam int unsigned CW   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned NOUT = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
  localparam int unsigned OW   = $clog2(NOUT + 1);

  if (IMG_WIDTH < 3 || IMG_HEIGHT < 3 || THRESHOLD < 0 || THRESHOLD > 4095) begin : g_cfg_check
    $error("sobel_stream_filter: unsupported parameter combination");
  end

  logic [7:0]      lb0 [IMG_WIDTH];
  logic [7:0]      lb1 [IMG_WIDTH];
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [OW-1:0]   out_count;
  logic            last_pixel_taken;
  logic            win_valid;
  logic [2:0][7:0] top, mid, bot;
  logic            en, accept, out_hs;

  logic [9:0]         gx_pos, gx_neg, gy_pos, gy_neg, ax, ay;
  logic signed [10:0] gx, gy;
  logic [11:0]        mag;
  logic [7:0]         next_data;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && busy && !frame_start && !last_pixel_taken;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready && !frame_start;

  // Window index [0] is the leftmost column; [2] is the newest.
  always_comb begin
    gx_pos = 10'(top[2]) + (10'(mid[2]) << 1) + 10'(bot[2]);
    gx_neg = 10'(top[0]) + (10'(mid[0]) << 1) + 10'(bot[0]);
    gy_pos = 10'(bot[0]) + (10'(bot[1]) << 1) + 10'(bot[2]);
    gy_neg = 10'(top[0]) + (10'(top[1]) << 1) + 10'(top[2]);
    gx     = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    gy     = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    ax     = gx[10] ? 10'(-gx) : gx[9:0];
    ay     = gy[10] ? 10'(-gy) : gy[9:0];
    mag    = 12'(ax) + 12'(ay);
`ifdef SOBEL_THRESH_EN
    next_data = (mag >= 12'(THRESHOLD)) ? 8'hFF : 8'h00;
`else
    next_data = (mag > 12'd255) ? 8'hFF : mag[7:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      out_valid        <= 1'b0;
      out_data         <= '0;
      col              <= '0;
      row              <= '0;
      out_count        <= '0;
      last_pixel_taken <= 1'b0;
      win_valid        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        busy             <= 1'b1;
        col              <= '0;
        row              <= '0;
        out_count        <= '0;
        out_valid        <= 1'b0;
        win_valid        <= 1'b0;
        last_pixel_taken <= 1'b0;
      end else begin
        if (accept) begin
          if (col == CW'(IMG_WIDTH - 1)) begin
            col <= '0;
            row <= row + 1'b1;
            if (row == RW'(IMG_HEIGHT - 1))
              last_pixel_taken <= 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        // col>=2 keeps columns left over from the previous row out of the window.
        if (en) begin
          win_valid <= accept && (row >= RW'(2)) && (col >= CW'(2));
          out_valid <= win_valid;
          out_data  <= next_data;
        end
        if (out_hs) begin
          if (out_count == OW'(NOUT - 1)) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            out_count  <= '0;
          end else begin
            out_count <= out_count + 1'b1;
          end
        end
      end
    end
  end

  // Line buffers and window carry no reset; stale contents are masked by win_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= in_data;
      top      <= {lb1[col], top[2], top[1]};
      mid      <= {lb0[col], mid[2], mid[1]};
      bot      <= {in_data,  bot[2], bot[1]};
    end
  end
endmodule
